// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, possibly asynchronous square wave in
// clk_in cycles, with lock detection on repeated periods and loss detection on stall.
module clk_period_meter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                sig_in,
  output logic [CNT_BITS-1:0] period,
  output logic [CNT_BITS-1:0] high_time,
  output logic                period_valid,
  output logic                locked,
  output logic                lost
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOST    = 2'd2;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                r_sig_p0;
  logic                r_sig_p1;
  logic                r_sig_p2;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] r_prev;
  logic [CNT_BITS-1:0] r_period;
  logic [CNT_BITS-1:0] r_high;
  logic                r_pv;
  logic                r_locked;
  logic                r_lost;
  logic [1:0]          r_state;

  logic w_rise;
  logic w_fall;
  logic w_sat;

  // Stage p0/p1: two-flop synchronizer; p2 delays the synchronized level for edge detect.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sig_p0 <= 1'b0;
      r_sig_p1 <= 1'b0;
      r_sig_p2 <= 1'b0;
    end else begin
      r_sig_p0 <= sig_in;
      r_sig_p1 <= r_sig_p0;
      r_sig_p2 <= r_sig_p1;
    end
  end

  assign w_rise = r_sig_p1 & ~r_sig_p2;
  assign w_fall = ~r_sig_p1 & r_sig_p2;
  assign w_sat  = (r_cnt == CNT_MAX);

  // Loading 1 on the rise makes the count at the next edge equal the true interval.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_ONE;
    end else begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  // Measurement FSM; a rise always takes priority over saturation.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
      r_high   <= '0;
      r_prev   <= '0;
      r_pv     <= 1'b0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_fall) r_high <= r_cnt;
          if (w_rise) begin
            r_period <= r_cnt;
            r_pv     <= 1'b1;
            r_locked <= (r_cnt == r_prev);
            r_prev   <= r_cnt;
          end else if (w_sat) begin
            r_state  <= ST_LOST;
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
            r_prev   <= '0;
          end
        end
        ST_LOST: begin
          if (w_rise) begin
            r_lost  <= 1'b0;
            r_state <= ST_MEASURE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign period       = r_period;
  assign high_time    = r_high;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign lost         = r_lost;

endmodule
